// File: rtl/systolic_ctrl.sv
// Purpose : sequencer for an N x N output-stationary FP8 x FP8 -> BF16 systolic array.
// Latency : start at edge E0 -> pe_clear in cycle 1, FEED cycles 2..3N-1, CAPTURE 3N, first result 3N+1.
// Backpr. : result stream is valid/ready; res_data/res_idx hold while res_ready=0, no timeout.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load_*            host tile write port (A/B buffers), accepted only in IDLE
//   start/busy/done   run control and status; done is a single-cycle pulse
//   pe_clear          clear for every PE accumulator
//   a_feed / b_feed   skewed west-edge / north-edge operands
//   c_in              BF16 accumulator outputs of the PE grid
//   res_*             row-major BF16 result stream
module systolic_ctrl #(
    parameter int N  = 2,
    parameter int AW = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                load_sel,
    input  logic [AW-1:0]       load_addr,
    input  logic [7:0]          load_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pe_clear,
    output logic [8*N-1:0]      a_feed,
    output logic [8*N-1:0]      b_feed,
    input  logic [16*N*N-1:0]   c_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [15:0]         res_data,
    output logic [AW-1:0]       res_idx
);

    localparam int NN        = N * N;
    localparam int SW        = $clog2(3 * N);
    localparam int STEP_LAST = 3 * N - 3;
    localparam logic [AW:0] NN_W = (AW + 1)'(NN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] step_q,  step_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic          done_q,  done_d;

    logic [7:0]    a_buf_q [NN];
    logic [7:0]    b_buf_q [NN];
    logic [15:0]   res_q   [NN];

    logic in_idle;
    logic load_we;

    assign in_idle = (state_q == S_IDLE);
    // Out-of-range addresses are dropped rather than aliased onto a real element.
    assign load_we = in_idle && load_valid && ({1'b0, load_addr} < NN_W);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                step_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (step_q == SW'(STEP_LAST)) begin
                    step_d  = '0;
                    state_d = S_CAPT;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_CAPT: begin
                idx_d   = '0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    if (idx_q == AW'(NN - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Tile buffers: written only in IDLE, persist across runs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < NN; e++) begin
                a_buf_q[e] <= '0;
                b_buf_q[e] <= '0;
            end
        end else if (load_we) begin
            if (load_sel) begin
                b_buf_q[load_addr] <= load_data;
            end else begin
                a_buf_q[load_addr] <= load_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result capture: the grid sees only zero operands during CAPTURE,
    // so c_in already holds the final accumulator values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < NN; e++) begin
                res_q[e] <= '0;
            end
        end else if (state_q == S_CAPT) begin
            for (int e = 0; e < NN; e++) begin
                res_q[e] <= c_in[16*e +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // Skewed edge operands. Row i of A enters i cycles late and column j
    // of B enters j cycles late, so the k-th products meet in PE(i,j) at
    // step i+j+k. Lanes outside their window carry zero.
    // ------------------------------------------------------------------
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (state_q == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (step_q == SW'(i + k)) begin
                        a_feed[8*i +: 8] = a_buf_q[AW'(i * N + k)];
                        b_feed[8*i +: 8] = b_buf_q[AW'(k * N + i)];
                    end
                end
            end
        end
    end

    // Outputs decoded straight from state so an async reset clears them at once.
    assign load_ready = in_idle;
    assign busy       = !in_idle;
    assign done       = done_q;
    assign pe_clear   = (state_q == S_CLEAR);
    assign res_valid  = (state_q == S_OUT);
    assign res_data   = (state_q == S_OUT) ? res_q[idx_q] : 16'h0000;
    assign res_idx    = (state_q == S_OUT) ? idx_q : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int NN = N * N;

    logic                clk;
    logic                rst;
    logic                load_valid;
    logic                load_ready;
    logic                load_sel;
    logic [AW-1:0]       load_addr;
    logic [7:0]          load_data;
    logic                start;
    logic                busy;
    logic                done;
    logic                pe_clear;
    logic [8*N-1:0]      a_feed;
    logic [8*N-1:0]      b_feed;
    logic [16*NN-1:0]    c_in;
    logic                res_valid;
    logic                res_ready;
    logic [15:0]         res_data;
    logic [AW-1:0]       res_idx;

    int checks = 0;
    int errors = 0;

    // Bench's view of the tile contents, expected results and captured results.
    logic [7:0]  ma  [NN];
    logic [7:0]  mb  [NN];
    logic [15:0] mc  [NN];
    logic [15:0] got [NN];

    systolic_ctrl #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pe_clear   (pe_clear),
        .a_feed     (a_feed),
        .b_feed     (b_feed),
        .c_in       (c_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- number formats ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp8(input logic [7:0] x);
        int  e;
        int  mi;
        real v;
        e  = int'(x[6:3]);
        mi = int'(x[2:0]);
        if (e == 0) v = (mi / 8.0) * pow2(-6);
        else        v = (1.0 + mi / 8.0) * pow2(e - 7);
        return x[7] ? -v : v;
    endfunction

    // Round-to-nearest-even conversion of a double to BF16.
    function automatic logic [15:0] bf16(input real r);
        logic [63:0] d;
        logic [15:0] t;
        if (r == 0.0) return 16'h0000;
        d = $realtobits(r);
        t = {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:45]};
        if (d[44] && ((|d[43:0]) || d[45])) t = t + 16'd1;
        return t;
    endfunction

    function automatic logic [7:0] rnd8();
        logic [7:0] x;
        x = 8'($urandom_range(0, 255));
        if (x[6:0] == 7'h7F) x = 8'h00;  // keep clear of NaN encodings
        return x;
    endfunction

    // ---------------- PE grid environment ----------------
    real        acc [N][N];
    logic [7:0] ar  [N][N];
    logic [7:0] br  [N][N];
    logic [7:0] an  [N][N];
    logic [7:0] bn  [N][N];

    always @(posedge clk or negedge rst) begin
        if (!rst || pe_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = 0.0;
                    ar[i][j]  = 8'h00;
                    br[i][j]  = 8'h00;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (j == 0) an[i][j] = a_feed[8*i +: 8];
                    else        an[i][j] = ar[i][j-1];
                    if (i == 0) bn[i][j] = b_feed[8*j +: 8];
                    else        bn[i][j] = br[i-1][j];
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = acc[i][j] + fp8(an[i][j]) * fp8(bn[i][j]);
                    ar[i][j]  = an[i][j];
                    br[i][j]  = bn[i][j];
                end
        end
        for (int e = 0; e < NN; e++) c_in[16*e +: 16] <= bf16(acc[e / N][e % N]);
    end

    // ---------------- reference and helpers ----------------
    task automatic compute_ref();
        real s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0.0;
                for (int k = 0; k < N; k++) s = s + fp8(ma[i*N+k]) * fp8(mb[k*N+j]);
                mc[i*N+j] = bf16(s);
            end
    endtask

    // Edge operands at FEED step t: lane i carries element t-i of its row/column.
    function automatic logic [8*N-1:0] exp_feed(input bit isb, input int t);
        logic [8*N-1:0] r;
        int k;
        r = '0;
        for (int i = 0; i < N; i++) begin
            k = t - i;
            if (k >= 0 && k < N) r[8*i +: 8] = isb ? mb[k*N+i] : ma[i*N+k];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_elem(input bit sel, input int addr, input logic [7:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = AW'(addr);
        load_data  = d;
        tick();
        load_valid = 1'b0;
        if (sel) mb[addr] = d;
        else     ma[addr] = d;
    endtask

    task automatic load_tiles(input logic [7:0] a [NN], input logic [7:0] b [NN]);
        for (int e = 0; e < NN; e++) load_elem(1'b0, e, a[e]);
        for (int e = 0; e < NN; e++) load_elem(1'b1, e, b[e]);
    endtask

    task automatic load_random();
        logic [7:0] a [NN];
        logic [7:0] b [NN];
        for (int e = 0; e < NN; e++) begin
            a[e] = rnd8();
            b[e] = rnd8();
        end
        load_tiles(a, b);
    endtask

    // mode 0: always ready, 1: random ready, 2: fixed stall/toggle pattern.
    // inject: write during FEED and start during OUTPUT, both must be ignored.
    task automatic run(input int mode, input bit inject);
        logic [15:0]   pd;
        logic [AW-1:0] pi;
        bit            stall;
        int            n;
        int            cyc;
        compute_ref();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3 * N; c++) begin
            chk("pe_clear", pe_clear, (c == 1));
            chk("a_feed", a_feed, exp_feed(1'b0, c - 2));
            chk("b_feed", b_feed, exp_feed(1'b1, c - 2));
            chk("res_valid_early", res_valid, 1'b0);
            chk("busy_run", busy, 1'b1);
            chk("load_ready_run", load_ready, 1'b0);
            if (inject && c == 2) begin
                load_valid = 1'b1;
                load_sel   = 1'b0;
                load_addr  = '0;
                load_data  = ~ma[0];
            end else begin
                load_valid = 1'b0;
            end
            tick();
        end
        load_valid = 1'b0;
        n = 0;
        cyc = 0;
        stall = 1'b0;
        pd = '0;
        pi = '0;
        while (n < NN && cyc < 200) begin
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = (cyc == 0) ? 1'b1 : (cyc <= 5) ? 1'b0 : (cyc % 2 == 0);
            endcase
            start = inject && (cyc == 0);
            chk("res_valid", res_valid, 1'b1);
            chk("done_early", done, 1'b0);
            if (stall) begin
                chk("hold_data", res_data, pd);
                chk("hold_idx", res_idx, pi);
            end
            if (res_ready) begin
                chk("res_idx", res_idx, n);
                chk("res_data", res_data, mc[n]);
                got[n] = res_data;
                n++;
            end
            stall = !res_ready;
            pd = res_data;
            pi = res_idx;
            tick();
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b0;
        chk("result_count", n, NN);
        chk("done_pulse", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("res_valid_after", res_valid, 1'b0);
        tick();
        chk("done_clear", done, 1'b0);
        chk("no_second_run", busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] ta [NN];
    logic [7:0] tb [NN];

    initial begin
        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        start      = 1'b0;
        res_ready  = 1'b0;
        for (int e = 0; e < NN; e++) begin
            ma[e] = 8'h00;
            mb[e] = 8'h00;
            got[e] = 16'h0000;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_pe_clear", pe_clear, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_a_feed", a_feed, 0);
        chk("rst_b_feed", b_feed, 0);
        chk("rst_res_data", res_data, 0);
        #1 rst = 1'b1;
        tick();

        // Identity multiply with known BF16 results.
        ta = '{8'h38, 8'h40, 8'h44, 8'h48};
        tb = '{8'h38, 8'h00, 8'h00, 8'h38};
        load_tiles(ta, tb);
        run(0, 1'b0);
        chk("ident_r0", got[0], 16'h3F80);
        chk("ident_r1", got[1], 16'h4000);
        chk("ident_r2", got[2], 16'h4040);
        chk("ident_r3", got[3], 16'h4080);

        // Backpressure pattern on random tiles.
        load_random();
        run(2, 1'b0);

        // Negative and denormal operands.
        ta = '{8'hB8, 8'h01, 8'h00, 8'h00};
        tb = '{8'h40, 8'h00, 8'h38, 8'h00};
        load_tiles(ta, tb);
        run(1, 1'b0);
        chk("neg_denorm_r0", got[0], 16'hC000);

        // Ignored write during FEED / start during OUTPUT, then rerun unchanged buffers.
        run(0, 1'b1);
        run(1, 1'b0);
        chk("persist_r0", got[0], 16'hC000);

        // Random tiles with random backpressure.
        for (int r = 0; r < 5; r++) begin
            load_random();
            run(1, 1'b0);
        end

        // Asynchronous reset in the middle of FEED.
        load_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_a_feed", a_feed, 0);
        chk("arst_b_feed", b_feed, 0);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_load_ready", load_ready, 1'b1);
        #3 rst = 1'b1;
        tick();
        for (int e = 0; e < NN; e++) begin
            ma[e] = 8'h00;
            mb[e] = 8'h00;
        end
        run(0, 1'b0);
        for (int e = 0; e < NN; e++) chk("post_rst_zero", got[e], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for an N x N output-stationary systolic array of FP8 E4M3 multiply / BF16-output accumulate PEs.
- Holds one A tile and one B tile (N x N FP8 each), loaded by a host port.
- On start: clears the array accumulators, streams diagonally skewed operands into the west/north edges, captures the N*N BF16 results, and returns them row-major over a valid/ready stream.
- Sits between the host/load logic and the PE grid; it is the only driver of PE clear and the edge operands.

Parameters:
N, 2, array dimension (rows = cols = reduction depth)
AW, $clog2(N*N), tile element index width (minimum 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
load_valid  in  1  host tile-write strobe
load_ready  out  1  1 only in IDLE
load_sel  in  1  0 = A buffer, 1 = B buffer
load_addr  in  AW  row-major index i*N+k (A) or k*N+j (B)
load_data  in  8  FP8 E4M3 element
start  in  1  begin a tile multiply; honoured only in IDLE
busy  out  1  1 in every state except IDLE
done  out  1  one-cycle pulse after the last result handshake
pe_clear  out  1  to the clear input of every PE
a_feed  out  8*N  [8*i +: 8] drives the a_in of PE(i,0)
b_feed  out  8*N  [8*j +: 8] drives the b_in of PE(0,j)
c_in  in  16*N*N  [16*(i*N+j) +: 16] is the BF16 c_out of PE(i,j)
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_data  out  16  BF16 result
res_idx  out  AW  i*N+j of res_data

Behaviour:
Reset (rst=0, async, any state):
- FSM goes to IDLE; the step counter and output index clear.
- A/B buffers and result registers clear to 0.
- All outputs are 0 except load_ready=1.

FSM states:
- IDLE: load_ready=1.
  - load_valid writes load_data to the selected buffer at load_addr on the edge.
  - load_addr >= N*N is ignored.
  - start -> CLEAR.
  - start together with load_valid: the write commits and is used by this run.
- CLEAR: exactly 1 cycle, pe_clear=1, feeds all zero -> FEED.
- FEED: exactly 3N-2 cycles, step t = 0..3N-3. At each step:
  - a_feed[i] = A[i][t-i] if 0 <= t-i < N, else 8'h00.
  - b_feed[j] = B[t-j][j] if 0 <= t-j < N, else 8'h00.
  - Zero operands add nothing to the accumulators.
  - After step 3N-3 -> CAPTURE.
- CAPTURE: 1 cycle, feeds zero.
  - Latch all of c_in into the result registers. With zero inputs at every PE, c_out equals the final accumulator.
  - -> OUTPUT.
- OUTPUT: res_valid=1; res_data = result[idx]; res_idx = idx, starting at 0.
  - On res_valid && res_ready, idx increments.
  - On the handshake at idx = N*N-1: done=1 on the next cycle and the FSM returns to IDLE.
  - res_data and res_idx are held stable while res_ready=0.
  - res_ready may stay low indefinitely; there is no timeout.

Outputs outside their states:
- a_feed, b_feed are 0 outside FEED.
- pe_clear is 0 outside CLEAR.
- res_valid is 0 outside OUTPUT.

Other rules:
- Latency: start sampled at edge E0; pe_clear is high in cycle 1; FEED spans cycles 2..3N-1; CAPTURE is cycle 3N; the first res_valid is in cycle 3N+1.
- start outside IDLE is ignored (not queued). load_valid outside IDLE is ignored and the buffers are unchanged.
- Buffers persist across runs; a second start with no reload reproduces the same results.
- done is high for exactly one cycle. busy is 0 in that cycle, so the FSM is already in IDLE and can accept start.
- Reset mid-run aborts immediately. There is no partial output, and the next run requires a reload.

Test Plan:
1. N=2. Load A = {0x38,0x40,0x44,0x48} (1,2,3,4) and B = identity {0x38,0x00,0x00,0x38}; start -> results in order idx 0..3 = 0x3F80, 0x4000, 0x4040, 0x4080, and done pulses once.
2. Timing, N=2, start at cycle 0 -> pe_clear=1 only in cycle 1. Feeds per cycle:
   - cycle 2: a_feed = {0, A00}
   - cycle 3: a_feed = {A10, A01}
   - cycle 4: a_feed = {A11, 0}
   - cycle 5: zero
   - b_feed mirrors this with B.
   - res_valid rises in cycle 7.
3. Backpressure: hold res_ready=0 for 5 cycles at idx 1, then toggle it every other cycle -> res_data and res_idx stay stable while stalled; no result is lost or duplicated; done appears only after idx 3 is accepted.
4. Negative and denormal operands: A = {0xB8 (-1), 0x01, 0, 0}, B = {0x40 (2), 0, 0x38, 0} -> res[0] = -2.0 (0xC000) plus the denormal contribution, checked against a reference model.
5. Rejected inputs:
   - load_valid during FEED -> buffer unchanged.
   - start during OUTPUT -> ignored; no second run begins.
6. rst=0 asserted mid-FEED -> busy, feeds and res_valid are 0 immediately (asynchronously). After release the FSM is in IDLE with buffers zero; a new start yields all-zero results.
